// File: rtl/trail_mem_arbiter_if.sv
// Bus bundle for the trail-map RAM arbiter: display fetch, game port,
// clear control and the RAM side. The arbiter takes the slave modport;
// the surrounding logic (or a bench) takes the master modport.
interface trail_mem_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 2
);
  // display fetch
  logic              disp_en;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_rdata;
  // game port
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              g_ack;
  logic              g_rvalid;
  logic [DATA_W-1:0] g_rdata;
  // clear sweep control
  logic              clear_req;
  logic              clear_busy;
  logic              clear_done;
  // RAM side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_en, disp_addr, g_req, g_we, g_addr, g_wdata, clear_req, mem_rdata,
    output disp_valid, disp_rdata, g_ack, g_rvalid, g_rdata,
           clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_en, disp_addr, g_req, g_we, g_addr, g_wdata, clear_req, mem_rdata,
    input  disp_valid, disp_rdata, g_ack, g_rvalid, g_rdata,
           clear_busy, clear_done, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/trail_mem_arbiter.sv
// trail_mem_arbiter: single-port arbiter for the Tron trail-map BRAM.
// Priority each cycle: display fetch > clear sweep > game port.
// The display fetch is never stalled; the RAM has 1-cycle read latency
// and read data is routed back via a registered owner tag.
// Optional feature macro: TRAIL_ARB_CLEAR_EN compiles in the clear FSM,
// its address counter and the clear priority level. Without it the
// clear outputs are tied low and clear_req is ignored.
module trail_mem_arbiter #(
  parameter int DEPTH     = 30000,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 2,
  parameter int CLEAR_VAL = 0
) (
  input  logic               clk_40MHz,
  input  logic               reset_n,
  trail_mem_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [DATA_W-1:0] CLR_V   = DATA_W'(CLEAR_VAL);

  logic              in_clear;   // FSM in CLEAR
  logic              clr_gnt;    // clear sweep owns the RAM this cycle
  logic [ADDR_W-1:0] clr_cnt;    // next address the sweep writes
  logic              disp_gnt;
  logic              game_gnt;
  logic              game_oor;   // game address beyond the grid
  logic              own_disp;   // registered owner tags for read data
  logic              own_game;
  logic              own_oor;

`ifdef TRAIL_ARB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH-1);

  state_t state;

  // Clear FSM: a display cycle holds the counter so no address is skipped
  always_ff @(posedge clk_40MHz or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (!bus.disp_en) begin
            if (clr_cnt == LAST) begin
              state   <= IDLE;
              clr_cnt <= '0;
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_clear       = (state == CLEAR);
  assign clr_gnt        = in_clear & ~bus.disp_en;
  assign bus.clear_busy = in_clear;
  // done pulses with the write of the last address, not a cycle later
  assign bus.clear_done = clr_gnt & (clr_cnt == LAST);
`else
  logic unused_clear_req;
  assign unused_clear_req = bus.clear_req;
  assign in_clear         = 1'b0;
  assign clr_gnt          = 1'b0;
  assign clr_cnt          = '0;
  assign bus.clear_busy   = 1'b0;
  assign bus.clear_done   = 1'b0;
`endif

  // Grants are gated by reset so every RAM-side output is quiet in reset
  assign disp_gnt  = reset_n & bus.disp_en;
  assign game_gnt  = reset_n & bus.g_req & ~bus.disp_en & ~in_clear;
  assign game_oor  = ({1'b0, bus.g_addr} >= DEPTH_X);
  assign bus.g_ack = game_gnt;

  // RAM port mux in priority order; out-of-range game access is acked
  // but never reaches the RAM
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (disp_gnt) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.disp_addr;
    end else if (clr_gnt) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = clr_cnt;
      bus.mem_wdata = CLR_V;
    end else if (game_gnt && !game_oor) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.g_we;
      bus.mem_addr  = bus.g_addr;
      bus.mem_wdata = bus.g_we ? bus.g_wdata : '0;
    end
  end

  // Owner tag for the read data arriving next cycle
  always_ff @(posedge clk_40MHz or negedge reset_n) begin
    if (!reset_n) begin
      own_disp <= 1'b0;
      own_game <= 1'b0;
      own_oor  <= 1'b0;
    end else begin
      own_disp <= disp_gnt;
      own_game <= game_gnt & ~bus.g_we & ~game_oor;
      own_oor  <= game_gnt & ~bus.g_we &  game_oor;
    end
  end

  assign bus.disp_valid = own_disp;
  assign bus.disp_rdata = own_disp ? bus.mem_rdata : '0;
  assign bus.g_rvalid   = own_game | own_oor;
  assign bus.g_rdata    = own_game ? bus.mem_rdata : '0;

endmodule
